// File: rtl/sram_sp_be_master_pkg.sv
// Shared types and constants for the byte-enable SRAM master.
// No logic; consumed by the interface, FIFO, master and SRAM model.
// No handshake here.
package sram_sp_be_master_pkg;

    // Two-phase controller: zero-fill sweep, then normal request service.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Response buffer entries. Two covers the 2-cycle read pipeline at full rate.
    localparam int RSP_FIFO_DEPTH = 2;

    // Address width for a given word count; at least one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_sp_be_master_if.sv
// Request/response bundle between a requester and the SRAM master.
// Pure wiring, no latency.
// Valid/ready on both channels; a beat moves when VAL && RDY.
interface sram_sp_be_master_if
    import sram_sp_be_master_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) ();

    localparam int AW = addr_bits(DEPTH);
    localparam int BW = WIDTH / 8;

    logic             REQ_VAL;
    logic             REQ_RDY;
    logic             REQ_WE;
    logic [BW-1:0]    REQ_BE;
    logic [AW-1:0]    REQ_ADDR;
    logic [WIDTH-1:0] REQ_WDATA;

    logic             RSP_VAL;
    logic             RSP_RDY;
    logic [WIDTH-1:0] RSP_RDATA;

    // Requester side.
    modport master (
        output REQ_VAL, REQ_WE, REQ_BE, REQ_ADDR, REQ_WDATA, RSP_RDY,
        input  REQ_RDY, RSP_VAL, RSP_RDATA
    );

    // SRAM master side.
    modport slave (
        input  REQ_VAL, REQ_WE, REQ_BE, REQ_ADDR, REQ_WDATA, RSP_RDY,
        output REQ_RDY, RSP_VAL, RSP_RDATA
    );

endinterface

// File: rtl/sram_sp_be.sv
// Single-port SRAM with per-byte write enables.
// Read data appears on DO the cycle after a read enable and holds until the next read.
// No flow control; accesses beyond DEPTH are ignored.
module sram_sp_be
    import sram_sp_be_master_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = addr_bits(DEPTH),
    localparam int BW   = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             EN,
    input  logic             WE,
    input  logic [BW-1:0]    WBE,
    input  logic [AW-1:0]    ADDR,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DO
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-merged write or registered read; DO is untouched by writes.
    always_ff @(posedge CLK) begin
        if (EN && (32'(ADDR) < 32'(DEPTH))) begin
            if (WE) begin
                for (int b = 0; b < BW; b++) begin
                    if (WBE[b]) mem[ADDR][8*b +: 8] <= DI[8*b +: 8];
                end
            end else begin
                DO <= mem[ADDR];
            end
        end
    end

endmodule

// File: rtl/sram_sp_be_master_sync_fifo_2.sv
// Two-entry synchronous FIFO holding read responses.
// Push at a clock edge is visible at the head the following cycle.
// Caller never pushes when full; pop only takes effect when non-empty.
module sync_fifo_2
    import sram_sp_be_master_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] mem [RSP_FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             pop;

    assign rd_vld = (count != 2'd0);
    assign pop    = rd_vld && rd_rdy;
    assign cnt    = count;
    // Head reads as zero when empty so the output is clean out of reset.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; push+pop in one cycle keeps count.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_vld) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, wr_vld} - {1'b0, pop};
        end
    end

    // Storage needs no reset; it is masked by rd_vld.
    always_ff @(posedge CLK) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/sram_sp_be_master.sv
// Valid/ready front end for a single-port byte-enable SRAM, with optional zero-fill.
// Reads return 2 cycles after accept; writes are posted with no response.
// REQ_RDY drops when buffered plus in-flight reads would exceed two response slots.
module sram_sp_be_master
    import sram_sp_be_master_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter bit INIT_ZERO = 1'b1,
    localparam int AW       = addr_bits(DEPTH),
    localparam int BW       = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    sram_sp_be_master_if.slave bus,
    output logic             SRAM_EN,
    output logic             SRAM_WE,
    output logic [BW-1:0]    SRAM_WBE,
    output logic [AW-1:0]    SRAM_ADDR,
    output logic [WIDTH-1:0] SRAM_DI,
    input  logic [WIDTH-1:0] SRAM_DO,
    output logic             INIT_DONE
);

    localparam state_t RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] init_cnt_q;
    logic          pend_q;
    logic          pend_oor_q;
    logic [1:0]    fifo_cnt;
    logic [2:0]    occupancy;
    logic          rsp_pop;
    logic          accept;
    logic          in_range;
    logic          run;

    assign run       = (state_q == ST_RUN);
    assign INIT_DONE = run;
    assign in_range  = (32'(bus.REQ_ADDR) < 32'(DEPTH));
    assign rsp_pop   = bus.RSP_VAL && bus.RSP_RDY;

    // Reads already committed to a response slot: buffered plus one in the SRAM pipe.
    // A pop this cycle frees a slot, so full-rate reads continue while RSP_RDY is high.
    assign occupancy   = {1'b0, fifo_cnt} + {2'b00, pend_q};
    assign bus.REQ_RDY = RST_N && run &&
                         (occupancy < (3'(RSP_FIFO_DEPTH) + {2'b00, rsp_pop}));
    assign accept      = bus.REQ_VAL && bus.REQ_RDY;

    // SRAM drive and next state: zero-fill sweep in INIT, pass-through in RUN.
    always_comb begin
        state_d   = state_q;
        SRAM_EN   = 1'b0;
        SRAM_WE   = 1'b0;
        SRAM_WBE  = '0;
        SRAM_ADDR = '0;
        SRAM_DI   = '0;
        case (state_q)
            ST_INIT: begin
                SRAM_EN   = RST_N;
                SRAM_WE   = 1'b1;
                SRAM_WBE  = '1;
                SRAM_ADDR = init_cnt_q;
                if (init_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                SRAM_EN   = accept && in_range;
                SRAM_WE   = bus.REQ_WE;
                SRAM_WBE  = bus.REQ_BE;
                SRAM_ADDR = bus.REQ_ADDR;
                SRAM_DI   = bus.REQ_WDATA;
            end
        endcase
    end

    // State register and sweep counter; reset always restarts the sweep at 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= RESET_STATE;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    // Track the read sitting in the SRAM pipe; out-of-range reads return zero.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pend_q     <= 1'b0;
            pend_oor_q <= 1'b0;
        end else begin
            pend_q     <= accept && !bus.REQ_WE;
            pend_oor_q <= !in_range;
        end
    end

    sync_fifo_2 #(.WIDTH(WIDTH)) u_rsp_fifo (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .wr_vld (pend_q),
        .wr_dat (pend_oor_q ? '0 : SRAM_DO),
        .rd_rdy (bus.RSP_RDY),
        .rd_vld (bus.RSP_VAL),
        .rd_dat (bus.RSP_RDATA),
        .cnt    (fifo_cnt)
    );

endmodule
